branch_predict_resolve: RTL and testbench

- Parametrised successor to the EX-stage branch condition evaluator.
- Adds a gshare direction predictor for the fetch stage: a pattern history table (PHT) of 2-bit saturating counters indexed by PC XOR global history register (GHR).
- Resolves branch conditions at DATA_W width in EX, detects mispredictions, trains the PHT and repairs the speculative GHR.
- Sits between fetch (lookup port) and execute (resolve port); mispredict output drives the pipeline flush/redirect logic.

---
 rtl/branch_predict_resolve_pkg.sv | 17 +
 rtl/branch_cond_eval.sv | 30 +++
 rtl/branch_predict_resolve.sv | 108 ++++++++++
 tb/tb_branch_predict_resolve.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/branch_predict_resolve_pkg.sv
// branch_predict_resolve_pkg: branch opcode encodings, PHT counter constants and saturating update
package branch_predict_resolve_pkg;
  localparam logic [7:0] EXE_BEQ_OP    = 8'b01010001;
  localparam logic [7:0] EXE_BNE_OP    = 8'b01010010;
  localparam logic [7:0] EXE_BGTZ_OP   = 8'b01010100;
  localparam logic [7:0] EXE_BLEZ_OP   = 8'b01010011;
  localparam logic [7:0] EXE_BLTZ_OP   = 8'b01000000;
  localparam logic [7:0] EXE_BLTZAL_OP = 8'b01001010;
  localparam logic [7:0] EXE_BGEZ_OP   = 8'b01000001;
  localparam logic [7:0] EXE_BGEZAL_OP = 8'b01001011;
  localparam logic [7:0] EXE_ADD_OP    = 8'b00100000;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_MAX = 2'b11;
  function automatic logic [1:0] cnt_update(input logic [1:0] c, input logic t);
    return t ? ((c == CNT_MAX) ? c : c + 2'd1) : ((c == 2'b00) ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational branch condition evaluator, signed compares on the operand MSB
module branch_cond_eval
  import branch_predict_resolve_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 8
) (
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] srca_i,
  input  logic [DATA_W-1:0] srcb_i,
  output logic              is_branch_o,
  output logic              take_o
);
  logic neg, zero;
  assign neg  = srca_i[DATA_W-1];
  assign zero = srca_i == '0;
  always_comb begin
    is_branch_o = 1'b1;
    take_o      = 1'b0;
    case (op_i)
      OP_W'(EXE_BEQ_OP):                        take_o = srca_i == srcb_i;
      OP_W'(EXE_BNE_OP):                        take_o = srca_i != srcb_i;
      OP_W'(EXE_BGTZ_OP):                       take_o = !neg && !zero;
      OP_W'(EXE_BLEZ_OP):                       take_o = neg || zero;
      OP_W'(EXE_BLTZ_OP), OP_W'(EXE_BLTZAL_OP): take_o = neg;
      OP_W'(EXE_BGEZ_OP), OP_W'(EXE_BGEZAL_OP): take_o = !neg;
      default:                                  is_branch_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: gshare predictor (lookup) plus EX branch resolve, PHT training and GHR repair
// Optional statistics counters enabled by BRANCH_STATS_EN.
module branch_predict_resolve
  import branch_predict_resolve_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PHT_DEPTH = 256,
  parameter int GHR_W     = 8,
  parameter int OP_W      = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              lookup_valid_i,
  input  logic [31:0]       lookup_pc_i,
  output logic              pred_valid_o,
  output logic              pred_taken_o,
  output logic [GHR_W-1:0]  pred_ghr_o,
  input  logic              resolve_valid_i,
  input  logic [OP_W-1:0]   resolve_op_i,
  input  logic [31:0]       resolve_pc_i,
  input  logic              resolve_pred_i,
  input  logic [GHR_W-1:0]  resolve_ghr_i,
  input  logic [DATA_W-1:0] srca_i,
  input  logic [DATA_W-1:0] srcb_i,
  output logic              branch_take_o,
  output logic              mispredict_o,
  output logic              actual_taken_o,
  output logic [GHR_W-1:0]  ghr_o,
  output logic [31:0]       stat_branches_o,
  output logic [31:0]       stat_mispredicts_o
);
  localparam int IDX_W = $clog2(PHT_DEPTH);
  logic [1:0] pht_q [PHT_DEPTH];
  logic [1:0] pht_d [PHT_DEPTH];
  logic [GHR_W-1:0] ghr_q, ghr_d, pred_ghr_q, pred_ghr_d;
  logic pred_valid_q, pred_valid_d, pred_taken_q, pred_taken_d;
  logic mispredict_q, mispredict_d, actual_q, actual_d;
  logic [IDX_W-1:0] lidx, ridx;
  logic is_br, rv_br, lk_bit;
  logic unused_pc;
  branch_cond_eval #(.DATA_W(DATA_W), .OP_W(OP_W)) u_eval (
    .op_i(resolve_op_i), .srca_i(srca_i), .srcb_i(srcb_i),
    .is_branch_o(is_br), .take_o(branch_take_o)
  );
  assign unused_pc = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0], resolve_pc_i[31:IDX_W+2], resolve_pc_i[1:0]};
  assign lidx   = lookup_pc_i[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign ridx   = resolve_pc_i[IDX_W+1:2] ^ IDX_W'(resolve_ghr_i);
  assign lk_bit = pht_q[lidx][1];
  assign rv_br  = resolve_valid_i & is_br;
  // Read uses pht_q, so a same-cycle resolve to the same index is seen only next cycle.
  always_comb begin
    pht_d = pht_q;
    if (rv_br) pht_d[ridx] = cnt_update(pht_q[ridx], branch_take_o);
    pred_valid_d = lookup_valid_i;
    pred_taken_d = lookup_valid_i & lk_bit;
    pred_ghr_d   = lookup_valid_i ? ghr_q : '0;
    mispredict_d = rv_br & (branch_take_o != resolve_pred_i);
    actual_d     = rv_br & branch_take_o;
    ghr_d        = mispredict_d   ? {resolve_ghr_i[GHR_W-2:0], branch_take_o} :
                   lookup_valid_i ? {ghr_q[GHR_W-2:0], lk_bit} : ghr_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= CNT_WNT;
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_ghr_q   <= '0;
      mispredict_q <= 1'b0;
      actual_q     <= 1'b0;
    end else begin
      pht_q        <= pht_d;
      ghr_q        <= ghr_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_ghr_q   <= pred_ghr_d;
      mispredict_q <= mispredict_d;
      actual_q     <= actual_d;
    end
  end
  assign pred_valid_o   = pred_valid_q;
  assign pred_taken_o   = pred_taken_q;
  assign pred_ghr_o     = pred_ghr_q;
  assign mispredict_o   = mispredict_q;
  assign actual_taken_o = actual_q;
  assign ghr_o          = ghr_q;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;
  always_comb begin
    stat_br_d = (rv_br && stat_br_q != '1) ? stat_br_q + 32'd1 : stat_br_q;
    stat_mp_d = (mispredict_d && stat_mp_q != '1) ? stat_mp_q + 32'd1 : stat_mp_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end
  assign stat_branches_o    = stat_br_q;
  assign stat_mispredicts_o = stat_mp_q;
`else
  assign stat_branches_o    = '0;
  assign stat_mispredicts_o = '0;
`endif
endmodule

// File: tb/tb_branch_predict_resolve.sv
// tb_branch_predict_resolve: scoreboard bench with a gshare reference model
module tb_branch_predict_resolve;
  import branch_predict_resolve_pkg::*;
  logic clk = 1'b0, resetn = 1'b0;
  logic lv, rv, rp;
  logic [31:0] lpc, rpc, a, b;
  logic [7:0] op, rg;
  logic pred_valid, pred_taken, take, mispredict, actual;
  logic [7:0] pred_ghr, ghr;
  logic [31:0] st_br, st_mp;
  always #5 clk = ~clk;
  branch_predict_resolve dut (
    .clk(clk), .resetn(resetn),
    .lookup_valid_i(lv), .lookup_pc_i(lpc),
    .pred_valid_o(pred_valid), .pred_taken_o(pred_taken), .pred_ghr_o(pred_ghr),
    .resolve_valid_i(rv), .resolve_op_i(op), .resolve_pc_i(rpc), .resolve_pred_i(rp),
    .resolve_ghr_i(rg), .srca_i(a), .srcb_i(b),
    .branch_take_o(take), .mispredict_o(mispredict), .actual_taken_o(actual),
    .ghr_o(ghr), .stat_branches_o(st_br), .stat_mispredicts_o(st_mp)
  );
  int n_chk = 0, n_bad = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  typedef struct packed {logic pv; logic pt; logic [7:0] pg; logic mp; logic at;} exp_t;
  exp_t sb[$];
  logic [1:0] m_pht [256];
  logic [7:0] m_ghr;
  logic [31:0] m_br, m_mp;
  logic [7:0] ops [9];
  function automatic logic m_isbr(input logic [7:0] o);
    return o inside {EXE_BEQ_OP, EXE_BNE_OP, EXE_BGTZ_OP, EXE_BLEZ_OP,
                     EXE_BLTZ_OP, EXE_BLTZAL_OP, EXE_BGEZ_OP, EXE_BGEZAL_OP};
  endfunction
  function automatic logic m_take(input logic [7:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o == EXE_BEQ_OP) return x == y;
    if (o == EXE_BNE_OP) return x != y;
    if (o == EXE_BGTZ_OP) return $signed(x) > 0;
    if (o == EXE_BLEZ_OP) return $signed(x) <= 0;
    if (o == EXE_BLTZ_OP || o == EXE_BLTZAL_OP) return $signed(x) < 0;
    if (o == EXE_BGEZ_OP || o == EXE_BGEZAL_OP) return $signed(x) >= 0;
    return 1'b0;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < 256; i++) m_pht[i] = 2'b01;
    m_ghr = 8'h00;
    m_br = 0;
    m_mp = 0;
    sb.delete();
  endtask
  task automatic idle_in();
    lv = 0; lpc = 0; rv = 0; op = 0; rpc = 0; rp = 0; rg = 0; a = 0; b = 0;
  endtask
  task automatic cyc(input logic l_v, input logic [31:0] l_pc, input logic r_v, input logic [7:0] r_op,
                     input logic [31:0] r_pc, input logic r_p, input logic [7:0] r_g,
                     input logic [31:0] x, input logic [31:0] y);
    logic [7:0] li, ri;
    logic pb, tk, br, mp;
    exp_t e;
    lv = l_v; lpc = l_pc; rv = r_v; op = r_op; rpc = r_pc; rp = r_p; rg = r_g; a = x; b = y;
    li = l_pc[9:2] ^ m_ghr;
    ri = r_pc[9:2] ^ r_g;
    pb = m_pht[li][1];
    tk = m_take(r_op, x, y);
    br = r_v & m_isbr(r_op);
    mp = br & (tk != r_p);
    e = '{l_v, l_v & pb, l_v ? m_ghr : 8'h00, mp, br & tk};
    sb.push_back(e);
    #1 check("branch_take", take, tk);
    if (br) begin
      m_pht[ri] = tk ? ((m_pht[ri] == 2'd3) ? 2'd3 : m_pht[ri] + 2'd1)
                     : ((m_pht[ri] == 2'd0) ? 2'd0 : m_pht[ri] - 2'd1);
      if (m_br != 32'hFFFFFFFF) m_br++;
    end
    if (mp && m_mp != 32'hFFFFFFFF) m_mp++;
    m_ghr = mp ? {r_g[6:0], tk} : l_v ? {m_ghr[6:0], pb} : m_ghr;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("pred_valid", pred_valid, e.pv);
    if (e.pv) begin
      check("pred_taken", pred_taken, e.pt);
      check("pred_ghr", pred_ghr, e.pg);
    end
    check("mispredict", mispredict, e.mp);
    check("actual_taken", actual, e.at);
    check("ghr", ghr, m_ghr);
`ifdef BRANCH_STATS_EN
    check("stat_br", st_br, m_br);
    check("stat_mp", st_mp, m_mp);
`else
    check("stat_br_off", st_br, 32'h0);
    check("stat_mp_off", st_mp, 32'h0);
`endif
  endtask
  task automatic check_reset_state(input string tag);
    check({tag, "_pv"}, pred_valid, 1'b0);
    check({tag, "_pt"}, pred_taken, 1'b0);
    check({tag, "_pg"}, pred_ghr, 8'h00);
    check({tag, "_mp"}, mispredict, 1'b0);
    check({tag, "_at"}, actual, 1'b0);
    check({tag, "_ghr"}, ghr, 8'h00);
    check({tag, "_pht40"}, dut.pht_q[8'h40], 2'b01);
    check({tag, "_sbr"}, st_br, 32'h0);
    check({tag, "_smp"}, st_mp, 32'h0);
  endtask
  initial begin
    ops = '{EXE_BEQ_OP, EXE_BNE_OP, EXE_BGTZ_OP, EXE_BLEZ_OP, EXE_BLTZ_OP,
            EXE_BLTZAL_OP, EXE_BGEZ_OP, EXE_BGEZAL_OP, EXE_ADD_OP};
    idle_in();
    m_reset();
    #12;
    check_reset_state("rst");
    resetn = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 32'h100, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 1, EXE_BEQ_OP, 32'h100, 0, 8'h00, 5, 5);
    check("pht40_after_beq", dut.pht_q[8'h40], 2'b10);
    cyc(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, EXE_BEQ_OP, 32'h100, 1, 8'h00, 7, 7);
      if (i == 0) check("pht40_sat3", dut.pht_q[8'h40], 2'b11);
    end
    check("pht40_stays3", dut.pht_q[8'h40], 2'b11);
    cyc(1, 32'h104, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 1, EXE_BGTZ_OP, 32'h200, 0, 8'h00, 32'h80000000, 0);
    cyc(0, 0, 1, EXE_BLEZ_OP, 32'h200, 1, 8'h00, 0, 0);
    cyc(0, 0, 1, EXE_ADD_OP, 32'h200, 1, 8'h00, 1, 1);
    cyc(0, 0, 1, EXE_BEQ_OP, 32'h300, 0, 8'h52, 1, 1);
    check("ghr_a5", ghr, 8'hA5);
    cyc(1, 32'h400, 1, EXE_BNE_OP, 32'h500, 1, 8'h0F, 3, 3);
    check("ghr_repair", ghr, 8'h1E);
    cyc(1, 32'h100, 1, EXE_BEQ_OP, 32'h178, 0, 8'h00, 9, 9);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] x;
      x = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      cyc(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2,
          1'($urandom_range(0, 1)), ops[$urandom_range(0, 8)], 32'($urandom_range(0, 255)) << 2,
          1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), x,
          ($urandom_range(0, 1) == 1) ? x : $urandom);
    end
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, EXE_BEQ_OP, 32'h100, 0, 8'h00, 4, 4);
    check("pht40_trained", dut.pht_q[8'h40], 2'b11);
    cyc(0, 0, 1, EXE_BEQ_OP, 32'h100, 0, 8'h00, 4, 4);
    idle_in();
    resetn = 1'b0;
    #1;
    m_reset();
    check_reset_state("midrst");
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 32'h100, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    cyc(1, 32'h100, 1, EXE_BEQ_OP, 32'h100, 0, 8'h00, 2, 2);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
